serial_nibble_comparator_ctrl: RTL and testbench
================================================

// Module: serial_nibble_comparator_ctrl
// PURPOSE
//   Compares two wide unsigned operands by sequencing one shared four_bit_comparator over them,
//   one nibble at a time, starting at the most significant nibble.
//   Stops at the first nibble that differs. Returns GT/LT/EQ through a valid/ready result port.
//   Sits between a requester that issues operand pairs and the 4-bit comparator datapath.
// PARAMETERS
//   NIBBLES  4  operand width in nibbles (operand width = 4*NIBBLES); legal range >= 1
// PORTS
//   i_CLK            in   1          clock; all logic on rising edge
//   i_RST            in   1          synchronous, active-high reset
//   i_START_VALID    in   1          operand pair on i_OPERAND_A/B is valid
//   o_START_READY    out  1          block can accept a new operand pair
//   i_OPERAND_A      in   4*NIBBLES  operand A, unsigned
//   i_OPERAND_B      in   4*NIBBLES  operand B, unsigned
//   o_RESULT_VALID   out  1          o_GT/o_LT/o_EQ/o_NIBBLES_USED are valid
//   i_RESULT_READY   in   1          consumer accepts the result
//   o_GT             out  1          A > B
//   o_LT             out  1          A < B
//   o_EQ             out  1          A == B
//   o_NIBBLES_USED   out  $clog2(NIBBLES+1)  number of nibbles compared before the decision (1..NIBBLES)
//   o_BUSY           out  1          high in CMP or DONE
// BEHAVIOUR
//   - Reset: state=IDLE. o_START_READY=1. o_RESULT_VALID=0, o_GT=0, o_LT=0, o_EQ=0,
//     o_NIBBLES_USED=0, o_BUSY=0. Operand registers and the nibble index are cleared.
//   - FSM states:
//     - IDLE: o_START_READY=1. When i_START_VALID is high:
//       - register A and B;
//       - set index=NIBBLES-1 and count=0;
//       - go to CMP.
//     - CMP: drive A_reg[4*index+:4] and B_reg[4*index+:4] into the comparator; count is incremented every cycle.
//       - Comparator reports GT or LT: register that flag and go to DONE.
//       - Comparator reports EQ and index==0: set o_EQ=1 and go to DONE.
//       - Comparator reports EQ and index!=0: decrement index and stay in CMP.
//     - DONE: o_RESULT_VALID=1 and the result is held stable.
//       - i_RESULT_READY high: clear o_RESULT_VALID and the flags, go to IDLE.
//       - The same cycle's i_START_VALID is not accepted.
//   - Handshake:
//     - A transfer occurs on a cycle where valid and ready are both high at the clock edge.
//     - Only one operation is in flight at a time. o_START_READY=0 in CMP and DONE.
//       i_START_VALID in those states is ignored and is not queued.
//     - Operand inputs are sampled only at the accept edge. Later changes on the inputs do not affect the result.
//     - Result outputs hold constant for every cycle that o_RESULT_VALID=1 and i_RESULT_READY=0.
//   - Latency: if the pair is accepted at edge t, o_RESULT_VALID rises at edge t+k.
//     k = o_NIBBLES_USED = number of nibbles examined, from 1 to NIBBLES.
//   - Invariants:
//     - When o_RESULT_VALID=1, exactly one of GT/LT/EQ is high.
//     - When o_RESULT_VALID=0, GT, LT and EQ are all 0.
//   - Comparator inputs are driven to 0 outside CMP. Their outputs are used only in CMP.
//   - Width rule: the index register is max(1,$clog2(NIBBLES)) bits wide.
//   - NIBBLES=1: CMP lasts exactly one cycle.
//   - Reset in any state: the next cycle is IDLE with all reset values applied, and the in-flight result is discarded.
// TESTING (NIBBLES=4)
//   - A=16'h1234, B=16'h1234 accepted ->
//     after 4 cycles: o_RESULT_VALID=1, EQ=1, GT=0, LT=0, o_NIBBLES_USED=4.
//   - A=16'h9000, B=16'h1FFF ->
//     after 1 cycle: GT=1, o_NIBBLES_USED=1.
//   - A=16'h12A4, B=16'h12A5 ->
//     after 4 cycles: LT=1, o_NIBBLES_USED=4. Also run A=16'h0000, B=16'hFFFF -> LT, o_NIBBLES_USED=1.
//   - Backpressure: hold i_RESULT_READY=0 for 5 cycles after the result ->
//     outputs stable, o_START_READY=0, a pulsed i_START_VALID is ignored.
//     Raise i_RESULT_READY -> IDLE on the next cycle.
//   - Operands change after accept: accept A=16'h00F0, B=16'h00E0, then drive the inputs to 0 ->
//     result is GT, o_NIBBLES_USED=3.
//   - Assert i_RST during the 2nd CMP cycle ->
//     next cycle IDLE with all reset values. A following EQ request completes normally.

Source files
------------

// File: rtl/serial_nibble_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// serial_nibble_comparator_ctrl
//
// Purpose:
//   Compares two wide unsigned operands by stepping one shared 4-bit
//   comparator across them, one nibble per cycle, starting at the most
//   significant nibble. The walk stops at the first nibble that differs.
//   The GT/LT/EQ verdict and the number of nibbles examined are returned
//   through a valid/ready result port.
//
// Ports:
//   i_CLK           clock, rising edge
//   i_RST           synchronous active-high reset
//   i_START_VALID   operand pair on i_OPERAND_A/B is valid
//   o_START_READY   block can accept a new operand pair (IDLE only)
//   i_OPERAND_A/B   unsigned operands, 4*NIBBLES bits wide
//   o_RESULT_VALID  result outputs are valid (DONE only)
//   i_RESULT_READY  consumer accepts the result
//   o_GT/o_LT/o_EQ  verdict flags, all zero while o_RESULT_VALID is low
//   o_NIBBLES_USED  nibbles examined before the decision (1..NIBBLES)
//   o_BUSY          high in CMP or DONE
//   o_DBG_STATE     current FSM state, for observation only
//
// Handshake: on both ports a transfer happens on a rising edge where valid
// and ready are both high. Only one operation is in flight; start requests
// while busy are dropped, not queued. Operands are captured only on the
// accept edge, and result outputs are held constant while stalled.
// ---------------------------------------------------------------------------

module four_bit_comparator (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       gt_o,
    output logic       lt_o,
    output logic       eq_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

module serial_nibble_comparator_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                           i_CLK,
    input  logic                           i_RST,
    input  logic                           i_START_VALID,
    output logic                           o_START_READY,
    input  logic [4*NIBBLES-1:0]           i_OPERAND_A,
    input  logic [4*NIBBLES-1:0]           i_OPERAND_B,
    output logic                           o_RESULT_VALID,
    input  logic                           i_RESULT_READY,
    output logic                           o_GT,
    output logic                           o_LT,
    output logic                           o_EQ,
    output logic [$clog2(NIBBLES+1)-1:0]   o_NIBBLES_USED,
    output logic                           o_BUSY,
    output logic [1:0]                     o_DBG_STATE
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CW   = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;
    logic            eq_q, eq_d;

    // Shared comparator datapath; inputs are forced to zero outside CMP.
    logic [3:0] cmp_a, cmp_b;
    logic       cmp_gt, cmp_lt, cmp_eq;

    four_bit_comparator u_cmp (
        .a_i  (cmp_a),
        .b_i  (cmp_b),
        .gt_o (cmp_gt),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        cmp_a   = 4'h0;
        cmp_b   = 4'h0;

        case (state_q)
            S_IDLE: begin
                if (i_START_VALID) begin
                    a_d     = i_OPERAND_A;
                    b_d     = i_OPERAND_B;
                    idx_d   = IDXW'(NIBBLES - 1);
                    cnt_d   = '0;
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                // {idx,2'b00} is 4*idx: bit offset of the current nibble.
                cmp_a = a_q[{idx_q, 2'b00} +: 4];
                cmp_b = b_q[{idx_q, 2'b00} +: 4];
                cnt_d = cnt_q + CW'(1);
                if (cmp_gt) begin
                    gt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cmp_lt) begin
                    lt_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cmp_eq) begin
                    if (idx_q == '0) begin
                        eq_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end

            S_DONE: begin
                // A start request in this same cycle is not seen: ready is low.
                if (i_RESULT_READY) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_START_READY  = (state_q == S_IDLE);
    assign o_RESULT_VALID = (state_q == S_DONE);
    assign o_BUSY         = (state_q == S_CMP) || (state_q == S_DONE);
    assign o_GT           = gt_q;
    assign o_LT           = lt_q;
    assign o_EQ           = eq_q;
    assign o_NIBBLES_USED = cnt_q;
    assign o_DBG_STATE    = state_q;

endmodule

// File: tb/tb_serial_nibble_comparator_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_nibble_comparator_ctrl
//
// Drives directed and random operand pairs into the serial nibble
// comparator and checks verdict, nibble count, latency, result hold under
// backpressure, dropped start requests and mid-operation reset against a
// reference model that compares the operands as plain integers.
// ---------------------------------------------------------------------------

module tb_serial_nibble_comparator_ctrl;
  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int CW = $clog2(N + 1);

  // clock / reset block
  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start_valid;
  logic          o_start_ready;
  logic [W-1:0]  i_operand_a;
  logic [W-1:0]  i_operand_b;
  logic          o_result_valid;
  logic          i_result_ready;
  logic          o_gt, o_lt, o_eq;
  logic [CW-1:0] o_nibbles_used;
  logic          o_busy;
  logic [1:0]    o_dbg_state;

  always #5 i_clk = ~i_clk;

  serial_nibble_comparator_ctrl #(.NIBBLES(N)) dut (
    .i_CLK          (i_clk),
    .i_RST          (i_rst),
    .i_START_VALID  (i_start_valid),
    .o_START_READY  (o_start_ready),
    .i_OPERAND_A    (i_operand_a),
    .i_OPERAND_B    (i_operand_b),
    .o_RESULT_VALID (o_result_valid),
    .i_RESULT_READY (i_result_ready),
    .o_GT           (o_gt),
    .o_LT           (o_lt),
    .o_EQ           (o_eq),
    .o_NIBBLES_USED (o_nibbles_used),
    .o_BUSY         (o_busy),
    .o_DBG_STATE    (o_dbg_state)
  );

  // scoreboard: expected {gt, lt, eq, nibbles_used}
  logic [5:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: integer comparison for the verdict, and the count of nibbles
  // from the top down to and including the first differing one.
  function automatic logic [5:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int  used;
    int  na, nb;
    logic g, l, e;
    used = N;
    for (int i = N - 1; i >= 0; i--) begin
      na = int'((a >> (4 * i)) & 16'hF);
      nb = int'((b >> (4 * i)) & 16'hF);
      if (na != nb) begin
        used = N - i;
        break;
      end
    end
    g = (a > b);
    l = (a < b);
    e = (a == b);
    return {g, l, e, 3'(used)};
  endfunction

  // driver: one full transaction with optional backpressure, a start pulse
  // during the stall, and a start request on the result handshake cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int bp, input bit pulse, input bit start_at_hs);
    logic [5:0] exp;
    logic [5:0] got;
    int k;
    k = 0;
    while (!o_start_ready && k < 50) begin
      @(posedge i_clk); #1; k++;
    end
    check("start_ready", o_start_ready, 1);
    i_start_valid = 1'b1;
    i_operand_a   = a;
    i_operand_b   = b;
    exp_q.push_back(model(a, b));
    @(posedge i_clk); #1;
    i_start_valid = 1'b0;
    i_operand_a   = W'($urandom);
    i_operand_b   = W'($urandom);
    check("busy_after_accept", o_busy, 1);
    check("sready_low_busy", o_start_ready, 0);

    k = 0;
    while (!o_result_valid && k < N + 4) begin
      @(posedge i_clk); #1; k++;
      if (!o_result_valid) check("flags_zero_cmp", {o_gt, o_lt, o_eq}, 0);
    end
    check("result_valid", o_result_valid, 1);
    exp = exp_q.pop_front();
    got = {o_gt, o_lt, o_eq, o_nibbles_used};
    check("result", got, exp);
    check("latency", k, exp[2:0]);
    check("onehot", $countones(got[5:3]), 1);

    for (int i = 0; i < bp; i++) begin
      if (pulse && i == 1) begin
        i_start_valid = 1'b1;
        i_operand_a   = W'($urandom);
        i_operand_b   = W'($urandom);
      end
      @(posedge i_clk); #1;
      i_start_valid = 1'b0;
      check("hold_result", {o_gt, o_lt, o_eq, o_nibbles_used}, exp);
      check("hold_valid", o_result_valid, 1);
      check("hold_sready", o_start_ready, 0);
    end

    i_result_ready = 1'b1;
    if (start_at_hs) i_start_valid = 1'b1;
    @(posedge i_clk); #1;
    i_result_ready = 1'b0;
    i_start_valid  = 1'b0;
    check("idle_after", {o_start_ready, o_result_valid, o_busy, o_gt, o_lt, o_eq}, 6'b100000);
    if (pulse || start_at_hs) begin
      @(posedge i_clk); #1;
      check("no_queued_start", {o_start_ready, o_busy}, 2'b10);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sready"}, o_start_ready, 1);
    check({tag, "_outs"}, {o_result_valid, o_gt, o_lt, o_eq, o_busy}, 0);
    check({tag, "_used"}, o_nibbles_used, 0);
  endtask

  logic [W-1:0] ra, rb, mask;
  int           mode, p;

  initial begin
    i_rst          = 1'b1;
    i_start_valid  = 1'b0;
    i_result_ready = 1'b0;
    i_operand_a    = '0;
    i_operand_b    = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // directed cases
    run_op(16'h1234, 16'h1234, 0, 1'b0, 1'b0);
    run_op(16'h9000, 16'h1FFF, 0, 1'b0, 1'b0);
    run_op(16'h12A4, 16'h12A5, 0, 1'b0, 1'b0);
    run_op(16'h0000, 16'hFFFF, 0, 1'b0, 1'b0);
    run_op(16'hABCD, 16'hAB00, 5, 1'b1, 1'b1);
    run_op(16'h00F0, 16'h00E0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFE, 2, 1'b0, 1'b1);

    // reset during the 2nd CMP cycle
    i_start_valid = 1'b1;
    i_operand_a   = 16'h1234;
    i_operand_b   = 16'h1234;
    @(posedge i_clk); #1;
    i_start_valid = 1'b0;
    @(posedge i_clk); #1;
    check("busy_2nd_cmp", o_busy, 1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_reset_values("mid_reset");
    repeat (N + 1) begin
      @(posedge i_clk); #1;
    end
    check("discarded_result", {o_result_valid, o_busy}, 0);
    run_op(16'h5A5A, 16'h5A5A, 0, 1'b0, 1'b0);

    // random stimulus, biased so every nibble position decides sometimes
    for (int n = 0; n < 150; n++) begin
      ra   = W'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: rb = W'($urandom);
        1: rb = ra;
        default: begin
          p    = $urandom_range(0, N - 1);
          rb   = ra ^ (W'($urandom_range(1, 15)) << (4 * p));
          mask = (W'(1) << (4 * p)) - W'(1);
          rb   = (rb & ~mask) | (W'($urandom) & mask);
        end
      endcase
      run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
